csr_access_initiator: RTL

- Execute-stage sequencer that turns one decoded Zicsr instruction into read/write cycles on the CSR slave bus consumed by mcounters and sibling CSR units.
- Accepts a request over valid/ready and reads the old CSR value.
- Issues at most one write strobe, then returns rd data or an illegal-instruction flag over a response valid/ready handshake.

---
 rtl/global_pkg.sv | 29 ++
 rtl/csr_access_initiator_decode.sv | 44 ++++
 rtl/csr_access_initiator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/global_pkg.sv
// Shared types for the execute-stage CSR units: write modes, Zicsr funct3
// encodings, the access-initiator FSM states and the read-only address prefix.
package global_pkg;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2
  } write_mode_t;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } csr_init_state_t;

  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

endpackage

// File: rtl/csr_access_initiator_decode.sv
// csr_req_decode: classifies a latched Zicsr request into a write mode,
// whether a write is intended, a bad-opcode flag and a read-only violation.
module csr_req_decode
  import global_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [ADDR_W-1:0] addr_i,
  output write_mode_t       mode_o,
  output logic              write_en_o,
  output logic              bad_op_o,
  output logic              ro_violation_o
);

  logic unusedAddrBits;
  assign unusedAddrBits = ^addr_i[ADDR_W-3:0];

  // Set/clear forms with rs1/uimm of zero are pure reads and must not write.
  always_comb begin
    mode_o     = CSR_WRITE;
    write_en_o = 1'b0;
    bad_op_o   = 1'b0;
    case (funct3_i)
      CSRRW, CSRRWI: begin
        mode_o     = CSR_WRITE;
        write_en_o = 1'b1;
      end
      CSRRS, CSRRSI: begin
        mode_o     = CSR_SET;
        write_en_o = (rs1_idx_i != 5'd0);
      end
      CSRRC, CSRRCI: begin
        mode_o     = CSR_CLEAR;
        write_en_o = (rs1_idx_i != 5'd0);
      end
      default: bad_op_o = 1'b1;
    endcase
  end

  assign ro_violation_o = (addr_i[ADDR_W-1 -: 2] == CSR_RO_PREFIX) && write_en_o;

endmodule

// File: rtl/csr_access_initiator.sv
// csr_access_initiator: sequences one decoded Zicsr instruction into a read
// cycle, an optional single write strobe and a held response on the CSR bus.
// Optional: define CSR_ACCESS_EVENT_EN to add the csr_event pulse output.
module csr_access_initiator
  import global_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_csr_addr,
  input  logic [4:0]        req_rs1_idx,
  input  logic [XLEN-1:0]   req_rs1_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rd_data,
  output logic              rsp_illegal,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              csr_wr,
  output write_mode_t       csr_write_mode,
  output logic [XLEN-1:0]   csr_din,
  input  logic [XLEN-1:0]   csr_dout,
  input  logic              csr_illegal
`ifdef CSR_ACCESS_EVENT_EN
  ,
  output logic              csr_event
`endif
);

  csr_init_state_t   state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        rs1Idx_q, rs1Idx_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [XLEN-1:0]   rdData_q, rdData_d;
  logic              illegal_q, illegal_d;

  write_mode_t       decMode;
  logic              decWriteEn;
  logic              decBadOp;
  logic              decRoViolation;
  logic              readIllegal;

  csr_req_decode #(.ADDR_W(ADDR_W)) uDecode (
    .funct3_i       (funct3_q),
    .rs1_idx_i      (rs1Idx_q),
    .addr_i         (addr_q),
    .mode_o         (decMode),
    .write_en_o     (decWriteEn),
    .bad_op_o       (decBadOp),
    .ro_violation_o (decRoViolation)
  );

  assign readIllegal = csr_illegal | decBadOp | decRoViolation;

  // State register and latched request fields, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      rs1Idx_q  <= 5'd0;
      operand_q <= '0;
      rdData_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      rs1Idx_q  <= rs1Idx_d;
      operand_q <= operand_d;
      rdData_q  <= rdData_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic: accept in IDLE, sample the slave in READ, strobe once
  // in WRITE, hold the response in RESP until writeback takes it.
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    rs1Idx_d  = rs1Idx_q;
    operand_d = operand_q;
    rdData_d  = rdData_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d  = req_funct3;
          addr_d    = req_csr_addr;
          rs1Idx_d  = req_rs1_idx;
          operand_d = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_data;
          state_d   = READ;
        end
      end
      READ: begin
        illegal_d = readIllegal;
        rdData_d  = readIllegal ? '0 : csr_dout;
        if (readIllegal)     state_d = RESP;
        else if (decWriteEn) state_d = WRITE;
        else                 state_d = RESP;
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rd_data    = rdData_q;
  assign rsp_illegal    = illegal_q;
  assign csr_addr       = addr_q;
  assign csr_wr         = (state_q == WRITE);
  assign csr_write_mode = decMode;
  assign csr_din        = operand_q;

`ifdef CSR_ACCESS_EVENT_EN
  logic event_q, event_d;

  assign event_d = ((state_q == READ) && !readIllegal && !decWriteEn) || (state_q == WRITE);

  // One-cycle pulse aligned with RESP entry for every legal access.
  always_ff @(posedge clk) begin
    if (rst) event_q <= 1'b0;
    else     event_q <= event_d;
  end

  assign csr_event = event_q;
`endif

endmodule
